// File: rtl/data_rdbuf_if.sv
// Read-buffer handshake bundle: BRAM strobe/data in,
// show-ahead word out, stall back to the requester.
interface data_rdbuf_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  i_rden;
  logic [DATA_WIDTH-1:0] i_rddata;
  logic                  o_stall;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_valid;
  logic                  i_ready;

  modport slave (
    input  i_rden,
    input  i_rddata,
    input  i_ready,
    output o_stall,
    output o_data,
    output o_valid
  );

  modport master (
    output i_rden,
    output i_rddata,
    output i_ready,
    input  o_stall,
    input  o_data,
    input  o_valid
  );
endinterface

// File: rtl/data_rdbuf.sv
// BRAM read-latency tracker plus show-ahead FIFO feeding the PE datapath.
// Optional perf counters: define DATA_RDBUF_PERF_CNT_EN.
module data_rdbuf #(
  parameter int DATA_WIDTH     = 32,
  parameter int RD_LATENCY     = 2,
  parameter int FIFO_DEPTH     = 8,
  parameter int FIFO_PTR_WIDTH = 3,
  parameter int REG_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  data_rdbuf_if.slave          bus,
  input  logic                 i_flush,
  output logic                 o_overflow,
  output logic [REG_WIDTH-1:0] dbg_rdbuf_cnt,
  output logic [REG_WIDTH-1:0] dbg_rdbuf_inflight,
  output logic [REG_WIDTH-1:0] dbg_rdbuf_stallcyc,
  output logic [REG_WIDTH-1:0] dbg_rdbuf_beats
);
  localparam int CW = FIFO_PTR_WIDTH + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [CW:0] LVL_FULL = (CW + 1)'(FIFO_DEPTH);
  localparam logic [FIFO_PTR_WIDTH-1:0] PTR_ONE = FIFO_PTR_WIDTH'(1);

  logic [RD_LATENCY-1:0]     vpipe;
  logic [RD_LATENCY:0]       vpipe_sh;
  logic [CW-1:0]             inflight;
  logic [CW-1:0]             cnt;
  logic [CW:0]               level;
  logic [FIFO_PTR_WIDTH-1:0] wr_ptr;
  logic [FIFO_PTR_WIDTH-1:0] rd_ptr;
  logic [DATA_WIDTH-1:0]     mem [FIFO_DEPTH];
  logic                      wr_en;
  logic                      full;
  logic                      pop;
  logic                      push;
  logic                      drop;

  assign vpipe_sh = {vpipe, bus.i_rden};
  assign wr_en    = vpipe[RD_LATENCY-1];
  assign full     = (cnt == CNT_FULL);
  assign pop      = bus.o_valid & bus.i_ready;
  assign push     = wr_en & (~full | pop);
  assign drop     = wr_en & full & ~pop;
  assign level    = {1'b0, cnt} + {1'b0, inflight};

  assign bus.o_valid = (cnt != '0);
  assign bus.o_stall = (level >= LVL_FULL);
  assign bus.o_data  = bus.o_valid ? mem[rd_ptr] : '0;

  // Count strobes still travelling through the BRAM latency.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + CW'(vpipe[i]);
    end
  end

  // Valid pipe, pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vpipe      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      o_overflow <= 1'b0;
    end else if (i_flush) begin
      vpipe      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      o_overflow <= 1'b0;
    end else begin
      vpipe <= vpipe_sh[RD_LATENCY-1:0];
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      if (push & ~pop) cnt <= cnt + CNT_ONE;
      else if (pop & ~push) cnt <= cnt - CNT_ONE;
      if (drop) o_overflow <= 1'b1;
    end
  end

  // Capture returning BRAM words; storage needs no reset.
  always_ff @(posedge clk) begin
    if (push && !i_flush) mem[wr_ptr] <= bus.i_rddata;
  end

  assign dbg_rdbuf_cnt      = REG_WIDTH'(cnt);
  assign dbg_rdbuf_inflight = REG_WIDTH'(inflight);

`ifdef DATA_RDBUF_PERF_CNT_EN
  logic [REG_WIDTH-1:0] stallcyc;
  logic [REG_WIDTH-1:0] beats;

  // Free-running stall and accepted-beat counters, reset only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallcyc <= '0;
      beats    <= '0;
    end else begin
      if (bus.o_stall) stallcyc <= stallcyc + REG_WIDTH'(1);
      if (pop && !i_flush) beats <= beats + REG_WIDTH'(1);
    end
  end

  assign dbg_rdbuf_stallcyc = stallcyc;
  assign dbg_rdbuf_beats    = beats;
`else
  assign dbg_rdbuf_stallcyc = '0;
  assign dbg_rdbuf_beats    = '0;
`endif
endmodule

// File: tb/tb_data_rdbuf.sv
// Testbench for data_rdbuf: vector table, directed corners,
// and random traffic against a queue-based reference model.
module tb_data_rdbuf;
  localparam int DW    = 32;
  localparam int L     = 2;
  localparam int DEPTH = 8;
  localparam int PW    = 3;
  localparam int RW    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_flush = 1'b0;
  logic          o_overflow;
  logic [RW-1:0] dbg_cnt;
  logic [RW-1:0] dbg_inf;
  logic [RW-1:0] dbg_stc;
  logic [RW-1:0] dbg_beats;

  data_rdbuf_if #(.DATA_WIDTH(DW)) bus ();

  data_rdbuf #(
    .DATA_WIDTH(DW),
    .RD_LATENCY(L),
    .FIFO_DEPTH(DEPTH),
    .FIFO_PTR_WIDTH(PW),
    .REG_WIDTH(RW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .i_flush(i_flush),
    .o_overflow(o_overflow),
    .dbg_rdbuf_cnt(dbg_cnt),
    .dbg_rdbuf_inflight(dbg_inf),
    .dbg_rdbuf_stallcyc(dbg_stc),
    .dbg_rdbuf_beats(dbg_beats)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  logic [31:0] exp_q[$];
  int          pend_q[$];
  int          cyc;
  bit          m_ovf;
  logic [31:0] m_stc;
  logic [31:0] m_beats;

  typedef struct {
    logic        rden;
    logic [31:0] rdata;
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    pend_q.delete();
    cyc = 0;
    m_ovf = 0;
    m_stc = '0;
    m_beats = '0;
  endtask

  task automatic check_model();
    chk("valid", bus.o_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) chk("data", bus.o_data, exp_q[0]);
    chk("stall", bus.o_stall, (exp_q.size() + pend_q.size()) >= DEPTH);
    chk("overflow", o_overflow, m_ovf);
    chk("cnt", dbg_cnt, exp_q.size());
    chk("inflight", dbg_inf, pend_q.size());
`ifdef DATA_RDBUF_PERF_CNT_EN
    chk("stallcyc", dbg_stc, m_stc);
    chk("beats", dbg_beats, m_beats);
`else
    chk("stallcyc_tied", dbg_stc, 0);
    chk("beats_tied", dbg_beats, 0);
`endif
  endtask

  task automatic model_update(input logic rden, input logic [31:0] rdata,
                              input logic ready, input logic flush);
    int  sz;
    bit  pop;
    sz = exp_q.size();
    if ((sz + pend_q.size()) >= DEPTH) m_stc++;
    if (flush) begin
      exp_q.delete();
      pend_q.delete();
      m_ovf = 0;
      cyc++;
      return;
    end
    pop = (sz != 0) && ready;
    if (pop) begin
      void'(exp_q.pop_front());
      m_beats++;
    end
    if (pend_q.size() != 0 && pend_q[0] + L == cyc) begin
      void'(pend_q.pop_front());
      if (sz == DEPTH && !pop) m_ovf = 1;
      else exp_q.push_back(rdata);
    end
    if (rden) pend_q.push_back(cyc);
    cyc++;
  endtask

  task automatic step(input logic rden, input logic [31:0] rdata,
                      input logic ready, input logic flush);
    check_model();
    bus.i_rden   = rden;
    bus.i_rddata = rdata;
    bus.i_ready  = ready;
    i_flush      = flush;
    @(posedge clk);
    model_update(rden, rdata, ready, flush);
    @(negedge clk);
  endtask

  initial begin
    int          first;
    int          last;
    int          nbeat;
    logic [31:0] got[$];
    logic        r;

    bus.i_rden   = 1'b0;
    bus.i_rddata = '0;
    bus.i_ready  = 1'b0;
    model_reset();

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_stall", bus.o_stall, 0);
    chk("rst_data", bus.o_data, 0);
    chk("rst_ovf", o_overflow, 0);
    chk("rst_cnt", dbg_cnt, 0);
    chk("rst_inflight", dbg_inf, 0);
    chk("rst_stc", dbg_stc, 0);
    chk("rst_beats", dbg_beats, 0);
    rst = 1'b1;
    @(negedge clk);

    // single read: strobe at cycle 5, data at 7, valid at 8
    for (int i = 0; i < 11; i++) begin
      tbl[i] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0};
    end
    tbl[5].rden = 1'b1;
    tbl[7].rdata = 32'hA5A5_0001;
    tbl[8].ready = 1'b1;
    tbl[8].exp_valid = 1'b1;
    tbl[8].exp_data = 32'hA5A5_0001;
    for (int i = 0; i < 11; i++) begin
      chk("tbl_valid", bus.o_valid, tbl[i].exp_valid);
      if (tbl[i].exp_valid) chk("tbl_data", bus.o_data, tbl[i].exp_data);
      step(tbl[i].rden, tbl[i].rdata, tbl[i].ready, 1'b0);
    end

    // steady state: 100 back-to-back reads, consumer always ready
    first = -1;
    last = -1;
    nbeat = 0;
    got.delete();
    for (int k = 0; k < 106; k++) begin
      if (bus.o_valid) begin
        if (first < 0) first = k;
        last = k;
        nbeat++;
        got.push_back(bus.o_data);
      end
      if (k < 100) chk("steady_nostall", bus.o_stall, 0);
      step(k < 100, 32'(k - 2), 1'b1, 1'b0);
    end
    chk("steady_beats", nbeat, 100);
    chk("steady_gapless", last - first + 1, 100);
    for (int j = 0; j < 100; j++) begin
      if (j < got.size()) chk("steady_order", got[j], j);
    end

    // burst with consumer stalled: fills exactly DEPTH
    for (int k = 0; k < 14; k++) begin
      step(!bus.o_stall, 32'(k - 2), 1'b0, 1'b0);
    end
    chk("burst_cnt", dbg_cnt, 8);
    chk("burst_stall", bus.o_stall, 1);
    chk("burst_ovf", o_overflow, 0);

    // protocol violation: read forced while full
    step(1'b1, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("viol_ovf", o_overflow, 1);
    chk("viol_cnt", dbg_cnt, 8);
    for (int j = 0; j < 8; j++) begin
      chk("drain_order", bus.o_data, j);
      step(1'b0, 32'h0, 1'b1, 1'b0);
    end
    chk("drain_empty", bus.o_valid, 0);
    chk("ovf_sticky", o_overflow, 1);

    // flush with cnt=5, inflight=2
    for (int k = 0; k < 7; k++) begin
      step(1'b1, 32'h200 + 32'(k), 1'b0, 1'b0);
    end
    chk("preflush_cnt", dbg_cnt, 5);
    chk("preflush_inf", dbg_inf, 2);
    step(1'b0, 32'h77, 1'b1, 1'b1);
    chk("flush_cnt", dbg_cnt, 0);
    chk("flush_inf", dbg_inf, 0);
    chk("flush_valid", bus.o_valid, 0);
    chk("flush_ovf", o_overflow, 0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 32'h77, 1'b0, 1'b0);
    end
    chk("flush_late", dbg_cnt, 0);

    // random traffic, occasionally ignoring stall
    for (int k = 0; k < 600; k++) begin
      r = ($urandom_range(0, 3) != 0) &&
          (!bus.o_stall || $urandom_range(0, 40) == 0);
      step(r, $urandom, $urandom_range(0, 2) != 0,
           $urandom_range(0, 60) == 0);
    end

    // async reset between edges mid-burst
    step(1'b0, 32'h0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 32'h300 + 32'(k), 1'b0, 1'b0);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", bus.o_valid, 0);
    chk("arst_stall", bus.o_stall, 0);
    chk("arst_cnt", dbg_cnt, 0);
    chk("arst_inf", dbg_inf, 0);
    chk("arst_ovf", o_overflow, 0);
    chk("arst_stc", dbg_stc, 0);
    chk("arst_beats", dbg_beats, 0);
    model_reset();
    bus.i_rden = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step(k < 2, 32'h400 + 32'(k), 1'b1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/data_rdbuf.md
Name: data_rdbuf

Overview:
- Sits directly downstream of data_req, between the data block RAM read port and the PE datapath.
- Tracks every read strobe issued by data_req through the fixed BRAM read latency and captures the returning words into a show-ahead FIFO.
- Presents the captured words to the consumer with a valid/ready handshake.
- Drives the stall input of data_req so the number of in-flight reads plus buffered words never exceeds FIFO capacity.

Parameters:
- DATA_WIDTH, 32, width of BRAM read data and output word
- RD_LATENCY, 2, BRAM read latency in cycles (legal range 1..4)
- FIFO_DEPTH, 8, buffer entries (power of two)
- FIFO_PTR_WIDTH, 3, log2(FIFO_DEPTH)
- REG_WIDTH, 32, width of debug/status outputs

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- i_rden  in  1  read strobe from data_req (o_rden)
- i_rddata  in  DATA_WIDTH  BRAM read data, valid RD_LATENCY cycles after i_rden
- o_stall  out  1  to data_req i_stall
- o_data  out  DATA_WIDTH  head-of-FIFO word
- o_valid  out  1  o_data valid
- i_ready  in  1  consumer accepts o_data
- i_flush  in  1  synchronous clear (end of layer / abort)
- o_overflow  out  1  sticky protocol-error flag
- dbg_rdbuf_cnt  out  REG_WIDTH  FIFO occupancy, zero-extended
- dbg_rdbuf_inflight  out  REG_WIDTH  reads in flight, zero-extended
- dbg_rdbuf_stallcyc  out  REG_WIDTH  stall-cycle counter (optional feature)
- dbg_rdbuf_beats  out  REG_WIDTH  accepted output beat counter (optional feature)

Behaviour:
- Reset (rst low, asynchronous):
  - Valid pipe, pointers, occupancy, in-flight count, o_overflow and debug counters all 0.
  - o_valid = 0; o_stall = 0; o_data = 0.
- Valid pipe:
  - RD_LATENCY-bit shift register, bit 0 loaded with i_rden each cycle.
  - wr_en = last bit.
  - inflight = popcount of pipe, width FIFO_PTR_WIDTH+1.
- Latency:
  - i_rden high in cycle t means i_rddata is sampled in cycle t+RD_LATENCY.
  - The word is written at the end of that cycle.
  - If the FIFO was empty, o_valid rises in cycle t+RD_LATENCY+1.
- FIFO:
  - Show-ahead: o_data = mem[rd_ptr]; o_valid = (cnt != 0).
  - Pop = o_valid & i_ready.
  - Push = wr_en.
  - Push and pop in the same cycle: cnt unchanged; legal at full and at empty+1.
  - Pointers wrap modulo FIFO_DEPTH.
  - cnt is FIFO_PTR_WIDTH+1 bits.
- Stall:
  - o_stall = (cnt + inflight) >= FIFO_DEPTH.
  - Purely from registered state; no path from i_rden, to avoid a loop through data_req.
  - A read is issued only when cnt + inflight <= FIFO_DEPTH-1, so a push can never hit a full FIFO.
- Overflow:
  - A push while cnt == FIFO_DEPTH with no pop (upstream ignored o_stall) drops the word.
  - The same condition sets o_overflow, which stays set until flush or reset.
- Flush (i_flush high):
  - Next edge clears the pipe, pointers, cnt and o_overflow.
  - An i_rden, push or pop in the flush cycle is discarded.
  - Debug counters are not cleared.
- Reset asserted mid-operation discards all in-flight data immediately; there is no recovery of lost reads.
- Consumer backpressure (i_ready low) holds o_data/o_valid stable.

Optional Feature:
- DATA_RDBUF_PERF_CNT_EN defined:
  - dbg_rdbuf_stallcyc increments every cycle o_stall is high.
  - dbg_rdbuf_beats increments on every pop.
  - Both are REG_WIDTH wide, wrap at 2^REG_WIDTH, and are cleared only by reset.
- Undefined: both ports are tied to 0 and no counter logic is built.

Test Plan:
- Single read, RD_LATENCY=2:
  - i_rden pulse at cycle 5 with i_rddata=0xA5A5_0001 at cycle 7.
  - Expect o_valid=1, o_data=0xA5A5_0001 at cycle 8; pop with i_ready=1, then o_valid=0.
- Burst with i_ready held low:
  - i_rden = ~o_stall continuously.
  - o_stall rises once cnt+inflight=8; exactly 8 words are buffered.
  - Expect no overflow and data in issue order 0..7.
- Steady state, i_ready=1:
  - Continuous reads for 100 cycles with incrementing data.
  - After fill, o_stall stays 0 and 100 beats are delivered in order with no gaps.
- Protocol violation:
  - Force i_rden=1 while o_stall=1 with FIFO full and i_ready=0.
  - Expect o_overflow=1, cnt stays 8, and the extra word never appears.
- Flush mid-stream:
  - i_flush with cnt=5, inflight=2.
  - Next cycle: cnt=0, inflight=0, o_valid=0, o_overflow=0; late BRAM data is not captured.
- Async reset:
  - rst low mid-burst between clock edges.
  - Expect o_valid and o_stall to be 0 immediately, before the next edge.
  - With DATA_RDBUF_PERF_CNT_EN, both perf counters read 0.
